// File: rtl/mnist_pixel_feeder.sv
// Double-buffered 28x28 frame feeder for the MNIST core.
// Stores frames from a byte stream and replays them as gap-free pixel bursts.
module mnist_pixel_feeder #(
    parameter int IMG_PIXELS        = 784,
    parameter int RESULTS_PER_FRAME = 10,
    parameter int GAP_CYCLES        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        res_valid,
    output logic        pix_valid,
    output logic [7:0]  pix_data,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] frames_done
);

    localparam int AW = $clog2(IMG_PIXELS);
    localparam int RW = $clog2(RESULTS_PER_FRAME + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(IMG_PIXELS - 1);
    localparam logic [RW-1:0] RES_TARGET = RW'(RESULTS_PER_FRAME);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_RES,
        GAP
    } state_t;

    // Frame storage, one array per bank.
    logic [7:0] mem0 [IMG_PIXELS];
    logic [7:0] mem1 [IMG_PIXELS];

    // Bank bookkeeping.
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;

    // Read FSM state.
    state_t        state_q, state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]   frames_done_q, frames_done_d;

    // Registered outputs.
    logic       pix_valid_q;
    logic [7:0] pix_data_q;
    logic       busy_q;
    logic       frame_err_q;

    // Write-side decode.
    logic wr_fire;
    logic wr_at_last;
    logic wr_good;
    logic wr_bad;

    // Read-side strobes.
    logic rd_en;
    logic rd_done;
    logic res_inc;

    assign s_ready    = ~full_q[wr_bank_q];
    assign wr_fire    = s_valid & s_ready;
    assign wr_at_last = (wr_cnt_q == LAST_ADDR);
    assign wr_good    = wr_fire & s_last & wr_at_last;
    // Early s_last or a missing s_last on the final byte both abort the frame.
    assign wr_bad     = wr_fire & (s_last ^ wr_at_last);

    // Write pointer and bank select next state.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q ^ wr_good;
        if (wr_fire) begin
            if (s_last || wr_at_last) begin
                wr_cnt_d = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    // Bank writes; no reset so the arrays can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_bank_q) begin
            mem0[wr_cnt_q] <= s_data;
        end
        if (wr_fire && wr_bank_q) begin
            mem1[wr_cnt_q] <= s_data;
        end
    end

    // Full flags: the banks are distinct, so a fill and a free can coincide.
    always_comb begin
        full_d = full_q;
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_good) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Read FSM next-state and counter logic.
    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        rd_bank_d     = rd_bank_q;
        res_cnt_d     = res_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frames_done_d = frames_done_q;
        rd_en         = 1'b0;
        rd_done       = 1'b0;
        res_inc       = res_valid && (res_cnt_q != RES_TARGET);
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = STREAM;
                    rd_cnt_d  = '0;
                    res_cnt_d = '0;
                end
            end
            STREAM: begin
                rd_en = 1'b1;
                if (res_inc) begin
                    res_cnt_d = res_cnt_q + 1'b1;
                end
                if (rd_cnt_q == LAST_ADDR) begin
                    rd_done   = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = WAIT_RES;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            WAIT_RES: begin
                if (res_inc) begin
                    res_cnt_d = res_cnt_q + 1'b1;
                end
                if (res_cnt_d == RES_TARGET) begin
                    frames_done_d = frames_done_q + 16'd1;
                    gap_cnt_d     = GAP_LOAD;
                    state_d       = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, flag, counter and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            state_q       <= IDLE;
            rd_cnt_q      <= '0;
            res_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            frames_done_q <= '0;
        end else begin
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            res_cnt_q     <= res_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frames_done_q <= frames_done_d;
        end
    end

    // Bank read doubles as the pixel output register (1-cycle latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            pix_valid_q <= rd_en;
            if (rd_en) begin
                pix_data_q <= rd_bank_q ? mem1[rd_cnt_q] : mem0[rd_cnt_q];
            end
        end
    end

    // Status outputs: busy tracks the FSM, frame_err pulses one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            busy_q      <= (state_d != IDLE);
            frame_err_q <= wr_bad;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_mnist_pixel_feeder.sv
// Scoreboard bench for mnist_pixel_feeder.
// Driver queues expected pixels; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mnist_pixel_feeder;

    localparam int IMG = 784;
    localparam int RES = 10;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        res_valid = 1'b0;
    logic        s_ready;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        busy;
    logic        frame_err;
    logic [15:0] frames_done;

    mnist_pixel_feeder #(
        .IMG_PIXELS(IMG),
        .RESULTS_PER_FRAME(RES),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .res_valid(res_valid),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .busy(busy),
        .frame_err(frame_err),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int gaps[$];
    int run_len = 0;
    int pix_total = 0;
    int bursts = 0;
    int idle_cnt = 0;
    int err_pulses = 0;
    int err_w = 0;
    logic prev_err = 1'b0;
    logic had_burst = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pixel scoreboard, burst length/gap and frame_err width.
    always @(negedge clk) begin
        if (rst) begin
            run_len   = 0;
            had_burst = 1'b0;
            prev_err  = 1'b0;
            err_w     = 0;
        end else begin
            if (pix_valid) begin
                if (run_len == 0 && had_burst) gaps.push_back(idle_cnt);
                run_len++;
                pix_total++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pix_extra: got %0d expected none", pix_data);
                end else begin
                    check("pix_data", pix_data, exp_q.pop_front());
                end
            end else begin
                if (run_len > 0) begin
                    check("burst_len", run_len, IMG);
                    bursts++;
                    had_burst = 1'b1;
                    idle_cnt  = 0;
                    run_len   = 0;
                end
                idle_cnt++;
            end
            if (frame_err) begin
                if (!prev_err) err_pulses++;
                err_w++;
            end else if (prev_err) begin
                check("frame_err_width", err_w, 1);
                err_w = 0;
            end
            prev_err = frame_err;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last,
                             output logic rdy0);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        rdy0 = s_ready;
        while (!s_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        s_last = 1'b0;
    endtask

    // last_at = 0 means no byte carries s_last.
    task automatic send_frame(input int n, input int last_at, input int seed,
                              input bit good, input bit hold,
                              output logic rdy_first);
        logic [7:0] d;
        logic r;
        rdy_first = 1'b1;
        for (int i = 0; i < n; i++) begin
            d = 8'(i + seed);
            if (good) exp_q.push_back(d);
            send_byte(d, (i + 1) == last_at, r);
            if (i == 0) rdy_first = r;
        end
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic send_res(input int n);
        repeat (n) begin
            res_valid = 1'b1;
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_bursts(input int target, input string name);
        int t;
        t = 0;
        while (bursts < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check(name, bursts >= target, 1);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int e0;
        int b0;
        int lat;
        int t;
        logic r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frames_done", frames_done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good frame: exact first-pixel latency.
        send_frame(IMG, IMG, 0, 1, 0, r);
        @(negedge clk);
        check("lat_e0_valid", pix_valid, 0);
        @(negedge clk);
        check("lat_e1_valid", pix_valid, 0);
        check("lat_e1_busy", busy, 1);
        @(negedge clk);
        check("lat_e2_valid", pix_valid, 1);
        check("lat_first_pix", pix_data, 0);
        wait_bursts(1, "burst1_end");

        // Result gating: 9 strobes hold the next stored frame back.
        send_res(9);
        send_frame(IMG, IMG, 100, 1, 0, r);
        p = pix_total;
        repeat (50) @(negedge clk);
        check("gate_no_stream", pix_total, p);
        check("gate_busy", busy, 1);
        check("gate_frames_done", frames_done, 0);
        @(posedge clk);
        #1 res_valid = 1'b1;
        @(posedge clk);
        #1 res_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) check("fd_after_10th", frames_done, 1);
            if (pix_valid) begin
                lat = k;
                break;
            end
        end
        check("gap_latency", lat, GAP + 2);
        wait_bursts(2, "burst2_end");
        send_res(RES);
        wait_idle("idle_after_f2");
        check("fd_two", frames_done, 2);

        // Early s_last on byte 100.
        @(posedge clk);
        #1;
        e0 = err_pulses;
        p  = pix_total;
        send_frame(100, 100, 5, 0, 0, r);
        @(negedge clk);
        check("early_err_hi", frame_err, 1);
        repeat (40) @(negedge clk);
        check("early_err_cnt", err_pulses, e0 + 1);
        check("early_no_stream", pix_total, p);
        check("early_busy", busy, 0);

        // Missing s_last on byte 784.
        @(posedge clk);
        #1;
        e0 = err_pulses;
        send_frame(IMG, 0, 9, 0, 0, r);
        @(negedge clk);
        check("miss_err_hi", frame_err, 1);
        repeat (40) @(negedge clk);
        check("miss_err_cnt", err_pulses, e0 + 1);
        check("miss_no_stream", pix_total, p);
        check("miss_busy", busy, 0);
        check("miss_s_ready", s_ready, 1);

        // Good frame after the bad ones.
        @(posedge clk);
        #1;
        send_frame(IMG, IMG, 33, 1, 0, r);
        wait_bursts(3, "burst3_end");
        send_res(RES);
        wait_idle("idle_after_f3");
        check("fd_three", frames_done, 3);

        // Back-to-back: three frames with s_valid held high.
        gaps.delete();
        b0 = bursts;
        fork
            begin
                logic r1;
                logic r3;
                @(posedge clk);
                #1;
                send_frame(IMG, IMG, 50, 1, 1, r1);
                send_frame(IMG, IMG, 60, 1, 1, r1);
                send_frame(IMG, IMG, 70, 1, 0, r3);
                check("b2b_sready_low", r3, 0);
            end
            begin
                for (int i = 1; i <= 3; i++) begin
                    wait_bursts(b0 + i, "b2b_burst_end");
                    send_res(RES);
                end
            end
        join
        wait_idle("idle_after_b2b");
        check("fd_six", frames_done, 6);
        check("b2b_gap_count", gaps.size(), 3);
        foreach (gaps[i]) check("b2b_gap_min", gaps[i] >= GAP + RES, 1);

        // Reset in the middle of a burst.
        @(posedge clk);
        #1;
        send_frame(IMG, IMG, 3, 1, 0, r);
        t = 0;
        while (run_len < 400 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("reach_pix400", run_len >= 400, 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_pix_valid", pix_valid, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_fd", frames_done, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        b0 = bursts;
        send_frame(IMG, IMG, 0, 1, 0, r);
        wait_bursts(b0 + 1, "post_rst_burst");
        send_res(RES);
        wait_idle("idle_post_rst");
        check("post_rst_fd", frames_done, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mnist_pixel_feeder.md
# mnist_pixel_feeder

Double-buffered frame feeder that sits directly upstream of the MNIST network core. It accepts 8-bit pixels from a byte source (UART receiver or host bridge) over a valid/ready handshake and stores one complete 28x28 frame per bank. It then replays each frame as an unbroken burst of single-cycle pixel strobes into the core's `valid_in`/`pixel_in`. It also paces frames: the next burst is not issued until the core has returned the expected number of `result_valid` strobes for the current frame.

## Interface
- `IMG_PIXELS`, 784: pixels per frame; also the depth of each bank.
- `RESULTS_PER_FRAME`, 10: count of core `result_valid` strobes that closes a frame.
- `GAP_CYCLES`, 4: idle cycles inserted after a frame closes, before the next burst. Legal range is ≥1.

- `clk`  in  1  single clock; all state is sampled on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `s_valid`  in  1  source byte is valid.
- `s_data`  in  8  source pixel, unsigned.
- `s_last`  in  1  marks the final byte of a frame; qualified by `s_valid`.
- `s_ready`  out  1  feeder can accept a byte.
- `res_valid`  in  1  connects to the core's `result_valid`.
- `pix_valid`  out  1  connects to the core's `valid_in`.
- `pix_data`  out  8  connects to the core's `pixel_in`.
- `busy`  out  1  high when the read FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse when an input frame is malformed.
- `frames_done`  out  16  count of closed frames; wraps from 0xFFFF to 0.

## Operation
- **Storage.** Two banks, each `IMG_PIXELS` x 8 bits. Each bank has a `full` flag.
  - `wr_bank` selects the bank being written; `rd_bank` selects the bank being read.
  - Both pointers reset to 0.
- **Write side.**
  - `s_ready` = !full[wr_bank].
  - A byte is accepted when `s_valid` and `s_ready` are both high. It is written at `wr_cnt`, and `wr_cnt` increments.
  - Good frame: `s_last` arrives on byte number `IMG_PIXELS` (`wr_cnt` = `IMG_PIXELS`-1). On that edge full[wr_bank] is set, `wr_bank` toggles and `wr_cnt` clears.
  - Early `s_last` (`wr_cnt` < `IMG_PIXELS`-1): pulse `frame_err`, clear `wr_cnt`, leave the bank empty and do not toggle `wr_bank`.
  - Missing `s_last` on byte `IMG_PIXELS`: same handling as an early `s_last`.
- **Read FSM**, states IDLE, STREAM, WAIT_RES, GAP:
  - IDLE -> STREAM when full[rd_bank] = 1. `rd_cnt` = 0.
  - STREAM: issue one bank read per cycle for `rd_cnt` = 0..`IMG_PIXELS`-1. When the last address is issued:
    - clear full[rd_bank] and toggle `rd_bank`;
    - go to WAIT_RES.
  - WAIT_RES: the result counter counts `res_valid` strobes. When it reaches `RESULTS_PER_FRAME`:
    - increment `frames_done`;
    - load the gap counter;
    - go to GAP.
  - GAP: stay for `GAP_CYCLES` cycles, then go to IDLE.
- **Result counting.** The result counter clears on entry to STREAM. `res_valid` strobes seen during STREAM also count. Strobes seen in GAP or IDLE are ignored.
- **Simultaneous events.** A write completing bank A on the same edge that STREAM frees bank B is legal. Each bank has its own flag, so both updates take effect.
- **Reset.** Reset may be asserted mid-operation. All flags, counters and pointers clear immediately, and any partially received or partially streamed frame is discarded.

## Timing
- **Reset values:** `s_ready`=1, `pix_valid`=0, `pix_data`=0, `busy`=0, `frame_err`=0, `frames_done`=0.
- **Outputs.** All outputs are registered except `s_ready`, which is combinational from the `full` flag and `wr_bank`.
- **Bank read.** Synchronous, 1-cycle latency. `pix_valid`/`pix_data` are registered from the read data and sent to the core.
- **Latency.** `full` is set on edge E. The FSM enters STREAM at E+1, and the first `pix_valid` is high after edge E+2.
- **Burst.** `pix_valid` is high for exactly `IMG_PIXELS` consecutive cycles with no bubbles. Pixels go out in write order.
- **Throughput.** The source may stream 1 byte per cycle. `s_ready` drops the cycle after the second bank fills while the first bank is still unread.
- **frame_err.** Asserts on the cycle after the offending byte edge, for exactly one cycle.

## Test plan
- **Good frame.** Write 784 bytes (value = index mod 256) with `s_last` on byte 784, then drive 10 `res_valid` strobes. Required: 784 consecutive `pix_valid` cycles with `pix_data` 0,1,..,255,0,..,15; first `pix_valid` 2 cycles after the last accept; `frames_done`=1.
- **Back-to-back frames.** Write 3 frames continuously with `s_valid` held high. Required: `s_ready` falls after frame 2 is stored and rises when frame 1's bank frees; the 3 bursts are separated by ≥`GAP_CYCLES` plus the result wait; `frames_done`=3.
- **Early s_last.** Assert `s_last` on byte 100. Required: one `frame_err` pulse, no `pix_valid`; the next good frame streams normally.
- **Missing s_last.** Send 784 bytes without `s_last`. Required: `frame_err` pulse, bank not marked full, `busy` stays 0.
- **Result gating.** After a burst, supply only 9 `res_valid` strobes. Required: the FSM holds in WAIT_RES and the next full frame does not stream; the 10th strobe releases it after `GAP_CYCLES`.
- **Reset mid-burst.** Assert `rst` at pixel 400. Required: `pix_valid`=0 immediately, `s_ready`=1, `frames_done`=0; a fresh frame then streams correctly from pixel 0.
